bp_cce_pending_write_arbiter: RTL
=================================

Name: bp_cce_pending_write_arbiter

Overview:
- Sequences and shares the single write port of the CCE pending-bit counters between several requesters, e.g. LCE request handling, memory response handling and the ucode FSM.
- After reset it runs a hardware sweep that clears every way group's counter, then grants one requester per cycle using round-robin arbitration.
- Sits between the CCE request/response pipelines and the pending-bit storage, and drives that storage's w_v/w_addr/bypass/pending/clear inputs.

Parameters:
- num_req_p, 3, number of write requesters (must be ≥2).
- num_way_groups_p, 64, number of way groups managed by this CCE (must be ≥1).
- paddr_width_p, 40, physical address width.
- lg_num_way_groups_lp, derived as `BSG_SAFE_CLOG2(num_way_groups_p), width of the sweep counter.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- req_v_i  in  num_req_p  per-requester write request valid.
- req_ready_o  out  num_req_p  per-requester grant; a write transfers when req_v_i[k] & req_ready_o[k].
- req_addr_i  in  num_req_p*paddr_width_p  per-requester address.
- req_bypass_hash_i  in  num_req_p  per-requester hash bypass.
- req_op_i  in  num_req_p*2  per-requester operation: 00 decrement, 01 increment, 10 clear, 11 illegal.
- stall_i  in  1  freezes arbitration while high.
- w_v_o  out  1  write valid to pending bits.
- w_addr_o  out  paddr_width_p  write address.
- w_addr_bypass_hash_o  out  1  write hash bypass.
- pending_o  out  1  1 = increment, 0 = decrement.
- clear_o  out  1  clear the counter to 0.
- init_done_o  out  1  high once the sweep has completed.
- illegal_op_o  out  1  one-cycle pulse when a granted request carries op 11.

Behaviour:
- State machine:
  - States: S_RESET, S_CLEAR, S_READY.
  - While reset_n_i=0 (asynchronous): state=S_RESET, sweep counter=0, rr pointer=0. All outputs are 0, including init_done_o and req_ready_o.
  - S_RESET → S_CLEAR on the first clock edge after reset deasserts.
  - S_CLEAR:
    - Each cycle, drive w_v_o=1, clear_o=1, pending_o=0, w_addr_bypass_hash_o=1, and w_addr_o = zero-extended sweep counter.
    - The counter increments each cycle. When counter == num_way_groups_p-1, go to S_READY.
    - The sweep therefore takes exactly num_way_groups_p cycles.
    - stall_i is ignored in S_CLEAR. req_ready_o=0 throughout.
  - S_READY: init_done_o=1 and remains 1 until the next reset. Arbitration is active.
- Arbitration in S_READY:
  - Purely combinational grant: zero-cycle latency from request to write.
  - If stall_i=1: req_ready_o=0, w_v_o=0, and the rr pointer holds.
  - Otherwise, grant the first k with req_v_i[k]=1, searching k = rr, rr+1, … modulo num_req_p. Exactly one bit of req_ready_o is set, and only when some req_v_i is set.
  - For the granted k:
    - w_v_o=1.
    - w_addr_o=req_addr_i[k].
    - w_addr_bypass_hash_o=req_bypass_hash_i[k].
    - clear_o = (op==10).
    - pending_o = (op==01).
  - op 11: w_v_o=0 for that cycle, the request is still consumed (ready=1), and illegal_op_o=1.
  - After a grant, rr ← (k+1) mod num_req_p, wrapping from num_req_p-1 to 0. With no grant, rr holds.
  - No requester starves: any continuously valid requester is granted within num_req_p cycles while stall_i=0.
  - Requesters must hold valid and payload stable until granted. The block does not buffer.
- Reset mid-sweep or mid-arbitration:
  - All state returns to S_RESET immediately, and outputs drop to 0 asynchronously.
  - The sweep restarts from way group 0 after reset is released.
- num_way_groups_p=1: the sweep lasts one cycle.
- The block performs no ordering or merging of same-way-group writes. Counter over/underflow is the requesters' responsibility.

Test Plan:
- num_way_groups_p=4, reset released at cycle 0, observed from the next edge → w_v_o=clear_o=bypass=1 with w_addr_o=0,1,2,3 on 4 consecutive cycles, then init_done_o=1 and no further writes.
- All 3 requesters valid continuously after init, ops inc/dec/clear → grants 0,1,2,0,1,2. Each write shows the matching pending_o/clear_o and that requester's address.
- Only req 2 valid (granted, rr→0), then req 0 and 1 both valid → req 0 granted first, then req 1. Idle cycles leave rr unchanged.
- stall_i=1 for 3 cycles with req 1 valid → req_ready_o=0 and w_v_o=0 for 3 cycles. Req 1 is granted in the cycle stall_i drops.
- Req 0 with op 11 → req_ready_o[0]=1, w_v_o=0, illegal_op_o=1 for one cycle. rr advances to 1.
- reset_n_i pulsed low during sweep index 2 of 8 → outputs 0 immediately. After release, the sweep restarts at address 0 and runs 8 cycles before init_done_o=1.

Source files
------------

// File: rtl/bp_cce_pending_write_arbiter.sv
// Write-port arbiter for the CCE pending-bit counters: clears every way group
// after reset, then grants one requester per cycle round-robin.
module bp_cce_pending_write_arbiter #(
  parameter int num_req_p            = 3,
  parameter int num_way_groups_p     = 64,
  parameter int paddr_width_p        = 40,
  parameter int lg_num_way_groups_lp = (num_way_groups_p == 1) ? 1 : $clog2(num_way_groups_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [num_req_p-1:0]                    req_v_i,
  output logic [num_req_p-1:0]                    req_ready_o,
  input  logic [num_req_p-1:0][paddr_width_p-1:0] req_addr_i,
  input  logic [num_req_p-1:0]                    req_bypass_hash_i,
  input  logic [num_req_p-1:0][1:0]               req_op_i,
  input  logic                                    stall_i,
  output logic                                    w_v_o,
  output logic [paddr_width_p-1:0]                w_addr_o,
  output logic                                    w_addr_bypass_hash_o,
  output logic                                    pending_o,
  output logic                                    clear_o,
  output logic                                    init_done_o,
  output logic                                    illegal_op_o
);

  localparam int lg_req_lp = $clog2(num_req_p);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_e;

  state_e                          state_r, state_n;
  logic [lg_num_way_groups_lp-1:0] cnt_r, cnt_n;
  logic [lg_req_lp-1:0]            rr_r, rr_n;
  logic                            grant_v;
  logic [lg_req_lp-1:0]            grant_idx;
  logic [1:0]                      op;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= S_RESET;
      cnt_r   <= '0;
      rr_r    <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      rr_r    <= rr_n;
    end
  end

  // First valid requester at or after the rr pointer, wrapping modulo num_req_p.
  always_comb begin
    int idx;
    idx       = 0;
    grant_v   = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_r) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!grant_v && req_v_i[idx]) begin
        grant_v   = 1'b1;
        grant_idx = lg_req_lp'(idx);
      end
    end
  end

  always_comb begin
    state_n              = state_r;
    cnt_n                = cnt_r;
    rr_n                 = rr_r;
    req_ready_o          = '0;
    w_v_o                = 1'b0;
    w_addr_o             = '0;
    w_addr_bypass_hash_o = 1'b0;
    pending_o            = 1'b0;
    clear_o              = 1'b0;
    init_done_o          = 1'b0;
    illegal_op_o         = 1'b0;
    op                   = req_op_i[grant_idx];
    case (state_r)
      S_RESET: state_n = S_CLEAR;
      S_CLEAR: begin
        w_v_o                = 1'b1;
        clear_o              = 1'b1;
        w_addr_bypass_hash_o = 1'b1;
        w_addr_o             = paddr_width_p'(cnt_r);
        cnt_n                = cnt_r + 1'b1;
        if (cnt_r == lg_num_way_groups_lp'(num_way_groups_p - 1)) begin
          cnt_n   = '0;
          state_n = S_READY;
        end
      end
      S_READY: begin
        init_done_o = 1'b1;
        if (!stall_i && grant_v) begin
          req_ready_o[grant_idx] = 1'b1;
          w_addr_o               = req_addr_i[grant_idx];
          w_addr_bypass_hash_o   = req_bypass_hash_i[grant_idx];
          // op 11 is consumed but never reaches the counters
          if (op == 2'b11) begin
            illegal_op_o = 1'b1;
          end else begin
            w_v_o     = 1'b1;
            clear_o   = (op == 2'b10);
            pending_o = (op == 2'b01);
          end
          rr_n = (grant_idx == lg_req_lp'(num_req_p - 1)) ? '0 : lg_req_lp'(grant_idx + 1'b1);
        end
      end
      default: state_n = S_RESET;
    endcase
  end

endmodule
